// File: rtl/tx_scheduler_if.sv
// Console transmit bus between the LC-3 store path, the debug requester and uart_tx.
// master = tx_scheduler side, slave = the CPU/debug/uart_tx environment.
interface tx_scheduler_if;
  logic        i_ddr_wr;
  logic [7:0]  i_ddr_byte;
  logic [15:0] o_dsr;
  logic        i_dbg_req;
  logic [7:0]  i_dbg_byte;
  logic        o_dbg_ack;
  logic        o_tx_dv;
  logic [7:0]  o_tx_byte;
  logic        i_tx_active;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_overflow;

  modport master (
    input  i_ddr_wr, i_ddr_byte, i_dbg_req, i_dbg_byte, i_tx_active, i_tx_done,
    output o_dsr, o_dbg_ack, o_tx_dv, o_tx_byte, o_busy, o_overflow
  );

  modport slave (
    output i_ddr_wr, i_ddr_byte, i_dbg_req, i_dbg_byte, i_tx_active, i_tx_done,
    input  o_dsr, o_dbg_ack, o_tx_dv, o_tx_byte, o_busy, o_overflow
  );
endinterface

// File: rtl/tx_scheduler.sv
// Byte FIFO + IDLE/SEND/WAIT sequencer feeding uart_tx from CPU DDR stores.
// Define TX_SCHEDULER_DEBUG_PORT_EN to add the round-robin debug-trace requester.
module tx_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic           i_Clk,
  input  logic           reset_,
  tx_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             full, empty, issue_ok, grant_cpu, grant_dbg, push, drop;
  logic [7:0]       head, issue_byte;
  logic             tx_dv_q, dbg_ack_q, ovf_q;
  logic [7:0]       tx_byte_q;

  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign head     = mem[rd_ptr[FIFO_AW-1:0]];
  // i_tx_active also holds off issue after a reset that aborted a frame
  assign issue_ok = (state == IDLE) && !bus.i_tx_active;

`ifdef TX_SCHEDULER_DEBUG_PORT_EN
  logic last_grant;  // 1 = debug was granted last

  assign grant_cpu  = issue_ok && !empty && (!bus.i_dbg_req || last_grant);
  assign grant_dbg  = issue_ok && bus.i_dbg_req && (empty || !last_grant);
  assign issue_byte = grant_cpu ? head : bus.i_dbg_byte;

  always_ff @(posedge i_Clk) begin
    if (reset_)                      last_grant <= 1'b1;
    else if (grant_cpu || grant_dbg) last_grant <= grant_dbg;
  end
`else
  logic unused_dbg;

  assign unused_dbg = ^{bus.i_dbg_req, bus.i_dbg_byte};
  assign grant_cpu  = issue_ok && !empty;
  assign grant_dbg  = 1'b0;
  assign issue_byte = head;
`endif

  // a full FIFO still takes a write when the head leaves in the same cycle
  assign push = bus.i_ddr_wr && (!full || grant_cpu);
  assign drop = bus.i_ddr_wr && full && !grant_cpu;

  always_ff @(posedge i_Clk) begin
    if (push && !reset_) mem[wr_ptr[FIFO_AW-1:0]] <= bus.i_ddr_byte;
  end

  always_ff @(posedge i_Clk) begin
    if (reset_) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      dbg_ack_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      tx_dv_q   <= 1'b0;
      dbg_ack_q <= 1'b0;
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (grant_cpu) rd_ptr <= rd_ptr + 1'b1;
      if (drop)      ovf_q  <= 1'b1;
      case (state)
        IDLE: if (grant_cpu || grant_dbg) begin
          state     <= SEND;
          tx_dv_q   <= 1'b1;
          tx_byte_q <= issue_byte;
          dbg_ack_q <= grant_dbg;
        end
        SEND:    state <= WAIT;
        WAIT:    if (bus.i_tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_tx_dv    = tx_dv_q;
  assign bus.o_tx_byte  = tx_byte_q;
  assign bus.o_dbg_ack  = dbg_ack_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_busy     = (state != IDLE);
  assign bus.o_dsr      = {~full, 15'b0};
endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Sequences the serial console path between the LC-3 core and `uart_tx`. CPU stores to DDR are buffered in a small byte FIFO. An optional debug-trace requester shares the transmitter with the CPU, arbitrated round-robin per byte. The block issues one-cycle `i_Tx_DV` pulses, waits for `o_Tx_Done`, and publishes DSR ready status back to the datapath, replacing the ad-hoc send/done glue around the display registers.

## Interface
- `FIFO_DEPTH`, 4: CPU byte FIFO entries. Power of two, minimum 2.
- `FIFO_AW`, 2: pointer width, equal to log2(`FIFO_DEPTH`).
- `i_Clk` in 1: system clock. Rising edge only.
- `reset_` in 1: **synchronous, active-high** reset (1 = reset), sampled on `i_Clk`.
- `i_ddr_wr` in 1: one-cycle strobe for a CPU store to DDR.
- `i_ddr_byte` in 8: DDR[7:0], valid with `i_ddr_wr`.
- `o_dsr` out 16: `{ready, 15'b0}`, where ready = FIFO not full.
- `i_dbg_req` in 1: debug byte pending. Level signal; held until ack.
- `i_dbg_byte` in 8: debug byte. Held stable while `i_dbg_req`=1.
- `o_dbg_ack` out 1: one-cycle pulse when the debug byte is issued.
- `o_tx_dv` out 1: to `uart_tx.i_Tx_DV`. One-cycle pulse.
- `o_tx_byte` out 8: to `uart_tx.i_Tx_Byte`. Held from pulse until next issue.
- `i_tx_active` in 1: from `uart_tx.o_Tx_Active`.
- `i_tx_done` in 1: from `uart_tx.o_Tx_Done`.
- `o_busy` out 1: 1 in SEND or WAIT.
- `o_overflow` out 1: sticky. Set when a CPU byte is dropped.

## Operation
- **FIFO.** Circular, with `FIFO_AW`+1-bit read/write pointers. Full = MSBs differ and low bits equal; empty = pointers equal. Pointers wrap modulo 2·`FIFO_DEPTH`.
- **Write rule.** A write is accepted if not full, or if a pop occurs in the same cycle.
- **Overflow.** A write when full with no pop drops the byte, leaves the FIFO unchanged, and sets `o_overflow`.
- **Simultaneous push and pop.** Count is unchanged. The popped byte is the old head.
- **FSM states.** IDLE, SEND, WAIT.
- **IDLE.** Candidates are CPU (FIFO not empty) and DBG (`i_dbg_req`).
  - Issue only when `i_tx_active`=0.
  - One candidate: grant it.
  - Both candidates: grant the one not granted last. The `last_grant` flop resets to DBG, so the CPU wins first.
  - On grant: next state SEND, load `o_tx_byte` (FIFO head, or `i_dbg_byte`), set `o_tx_dv`=1, and update `last_grant`.
  - CPU grant pops the FIFO. DBG grant sets `o_dbg_ack`=1.
- **SEND.** Lasts exactly one cycle. `o_tx_dv` and `o_dbg_ack` return to 0. Next state WAIT.
- **WAIT.** Stay until `i_tx_done`=1, then go to IDLE.
- **Ignored done.** `i_tx_done` seen in IDLE or SEND is ignored.
- **`o_dsr`.** Combinational from the FIFO full flag. Bits [14:0] are always 0.
- **Reset values.**
  - State IDLE, pointers 0 (empty).
  - `o_dsr`=16'h8000, `o_tx_dv`=0, `o_tx_byte`=0, `o_dbg_ack`=0, `o_busy`=0, `o_overflow`=0.
- **Reset mid-transmission.** The FIFO contents are discarded and the state returns to IDLE. `uart_tx` is not reset, so the aborted frame finishes on the line. The `i_tx_active` gate blocks any new issue until that frame ends, and its trailing `i_tx_done` is ignored in IDLE.
- **Reset priority.** Reset overrides a write in the same cycle. The byte is lost and `o_overflow` is not set.

## Timing
- All outputs are registered except `o_dsr` and `o_busy`, which are decoded from registered state.
- CPU path latency:
  - `i_ddr_wr` in cycle N: FIFO non-empty from N+1.
  - `o_tx_dv` high in N+2, provided the FSM is in IDLE and `i_tx_active`=0.
- Debug path latency: `i_dbg_req` rising in N gives `o_tx_dv` and `o_dbg_ack` high together in N+1, if IDLE.
- Minimum spacing: `i_tx_done` in cycle M allows the next `o_tx_dv` no earlier than M+2 (M+1 is IDLE evaluation).
- `o_dsr[15]` falls in the cycle after the write that fills the FIFO. It rises in the cycle after the pop from full.

## Configuration
- Macro: `TX_SCHEDULER_DEBUG_PORT_EN`.
- **Defined:** debug requester and round-robin arbitration as above.
- **Undefined:**
  - `i_dbg_req` and `i_dbg_byte` are ignored, and `o_dbg_ack` is tied to 0.
  - The CPU is the sole requester and `last_grant` is omitted.
  - All other timing is identical.

## Test plan
- **Basic send:** reset, then write 8'h41 → `o_tx_dv` pulses 2 cycles later with `o_tx_byte`=8'h41. Model `uart_tx` done 100 cycles later → IDLE and `o_busy`=0.
- **Overflow:** hold done low and write 6 bytes 8'h30–8'h35 (DEPTH=4) → first is in flight and FIFO holds 31–34. 8'h35 is dropped, `o_overflow`=1, `o_dsr`=16'h0000. Draining sends 30–34 in order and `o_dsr` returns to 16'h8000.
- **Arbitration (macro on):** FIFO holds 8'h61, 8'h62 and `i_dbg_req` is held with 8'hD0, then 8'hD1 → issue order 61, D0, 62, D1. `o_dbg_ack` pulses coincide with the D0 and D1 `o_tx_dv`.
- **Full-boundary write:** FIFO full, and a write coincides with the IDLE pop → write accepted and `o_overflow` stays 0.
- **Reset mid-frame:** assert `reset_` in WAIT with `i_tx_active`=1 and 2 bytes queued → FIFO empty, no `o_tx_dv` until `i_tx_active` falls. The stray done is ignored and a new write then sends normally.
- **Macro off:** `i_dbg_req`=1 throughout → `o_dbg_ack` never asserts and only CPU bytes are issued.
